// File: rtl/pwm_multi_ch_gen.sv
// rtl/pwm_multi_ch_gen.sv - multi-channel programmable PWM generator
// Purpose: NUM_CH independent PWM channels. Each channel has staged
//   period/duty/phase/burst registers, a polarity bit and synchronous-start
//   arming. Period/duty changes in RUN are applied only at period end.
// Ports:
//   sys_clk     system clock, rising edge
//   sys_rst     asynchronous active-high reset
//   cfg_wr      single-cycle register write strobe
//   cfg_ch      target channel (>= NUM_CH ignored)
//   cfg_addr    0 CTRL{sync,pol,en}, 1 PERIOD, 2 DUTY, 3 PHASE, 4 BURST
//   cfg_wdata   write data
//   sync_start  starts all ARMED channels on the same edge
//   pwm_out     registered PWM outputs
//   pwm_busy    channel running (aligned with pwm_out)
//   pwm_valid   one-cycle pulse at burst completion
module pwm_multi_ch_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int BURST_WIDTH = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 cfg_wr,
  input  logic [3:0]           cfg_ch,
  input  logic [2:0]           cfg_addr,
  input  logic [CNT_WIDTH-1:0] cfg_wdata,
  input  logic                 sync_start,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic [NUM_CH-1:0]    pwm_busy,
  output logic [NUM_CH-1:0]    pwm_valid
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_RUN = 2'd2} state_t;
  typedef logic [CNT_WIDTH-1:0]   cnt_t;
  typedef logic [BURST_WIDTH-1:0] bcnt_t;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PERIOD = 3'd1;
  localparam logic [2:0] ADDR_DUTY   = 3'd2;
  localparam logic [2:0] ADDR_PHASE  = 3'd3;
  localparam logic [2:0] ADDR_BURST  = 3'd4;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t state_q, state_d;
    logic   en_q, en_d, pol_q, pol_d, sync_q, sync_d;
    cnt_t   stg_period_q, stg_period_d, stg_duty_q, stg_duty_d;
    cnt_t   stg_phase_q, stg_phase_d;
    bcnt_t  stg_burst_q, stg_burst_d;
    cnt_t   act_period_q, act_period_d, act_duty_q, act_duty_d;
    bcnt_t  act_burst_q, act_burst_d;
    cnt_t   cnt_q, cnt_d, start_cnt;
    bcnt_t  burst_cnt_q, burst_cnt_d, burst_inc;
    logic   out_q, out_d, busy_q, busy_d, valid_q, valid_d;
    logic   sel, wr_ctrl, dis, period_end, done, run_now;

    assign sel     = cfg_wr && (cfg_ch == 4'(g));
    assign wr_ctrl = sel && (cfg_addr == ADDR_CTRL);
    // A disabling CTRL write acts on its own acceptance edge, so it beats
    // both sync_start and a burst completing in the same cycle.
    assign dis     = wr_ctrl && !cfg_wdata[0];

    // Start values come from the post-write staging so a same-cycle write
    // is honoured; phase beyond the period falls back to 0.
    assign start_cnt  = (stg_phase_d > stg_period_d) ? '0 : stg_phase_d;
    assign period_end = (cnt_q >= act_period_q);
    assign burst_inc  = (&burst_cnt_q) ? burst_cnt_q : burst_cnt_q + bcnt_t'(1);

    always_comb begin
      stg_period_d = stg_period_q;
      stg_duty_d   = stg_duty_q;
      stg_phase_d  = stg_phase_q;
      stg_burst_d  = stg_burst_q;
      if (sel) begin
        case (cfg_addr)
          ADDR_PERIOD: stg_period_d = cfg_wdata;
          ADDR_DUTY:   stg_duty_d   = cfg_wdata;
          ADDR_PHASE:  stg_phase_d  = cfg_wdata;
          ADDR_BURST:  stg_burst_d  = cfg_wdata[BURST_WIDTH-1:0];
          default:     ;
        endcase
      end
    end

    always_comb begin
      en_d   = en_q;
      pol_d  = pol_q;
      sync_d = sync_q;
      if (wr_ctrl) begin
        en_d   = cfg_wdata[0];
        pol_d  = cfg_wdata[1];
        sync_d = cfg_wdata[2];
      end
      state_d     = state_q;
      cnt_d       = cnt_q;
      burst_cnt_d = burst_cnt_q;
      done        = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en_q && !dis) begin
            if (sync_q) begin
              state_d = S_ARMED;
            end else begin
              state_d     = S_RUN;
              cnt_d       = start_cnt;
              burst_cnt_d = '0;
            end
          end
        end
        S_ARMED: begin
          if (dis) begin
            state_d = S_IDLE;
          end else if (sync_start) begin
            state_d     = S_RUN;
            cnt_d       = start_cnt;
            burst_cnt_d = '0;
          end
        end
        S_RUN: begin
          if (dis) begin
            state_d = S_IDLE;
          end else if (period_end) begin
            cnt_d       = '0;
            burst_cnt_d = burst_inc;
            if ((act_burst_q != '0) && (burst_inc == act_burst_q)) begin
              done    = 1'b1;
              state_d = S_IDLE;
              en_d    = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Active copies track staging outside RUN; in RUN only period/duty
      // move, and only on the wrap, so no period is ever truncated.
      act_period_d = act_period_q;
      act_duty_d   = act_duty_q;
      act_burst_d  = act_burst_q;
      if (state_q != S_RUN) begin
        act_period_d = stg_period_d;
        act_duty_d   = stg_duty_d;
        act_burst_d  = stg_burst_d;
      end else if (period_end) begin
        act_period_d = stg_period_d;
        act_duty_d   = stg_duty_d;
      end

      run_now = (state_q == S_RUN) && !dis;
      out_d   = run_now ? ((cnt_q < act_duty_q) ^ pol_d) : pol_d;
      busy_d  = run_now && !done;
      valid_d = done;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        state_q      <= S_IDLE;
        en_q         <= 1'b0;
        pol_q        <= 1'b0;
        sync_q       <= 1'b0;
        stg_period_q <= '0;
        stg_duty_q   <= '0;
        stg_phase_q  <= '0;
        stg_burst_q  <= '0;
        act_period_q <= '0;
        act_duty_q   <= '0;
        act_burst_q  <= '0;
        cnt_q        <= '0;
        burst_cnt_q  <= '0;
        out_q        <= 1'b0;
        busy_q       <= 1'b0;
        valid_q      <= 1'b0;
      end else begin
        state_q      <= state_d;
        en_q         <= en_d;
        pol_q        <= pol_d;
        sync_q       <= sync_d;
        stg_period_q <= stg_period_d;
        stg_duty_q   <= stg_duty_d;
        stg_phase_q  <= stg_phase_d;
        stg_burst_q  <= stg_burst_d;
        act_period_q <= act_period_d;
        act_duty_q   <= act_duty_d;
        act_burst_q  <= act_burst_d;
        cnt_q        <= cnt_d;
        burst_cnt_q  <= burst_cnt_d;
        out_q        <= out_d;
        busy_q       <= busy_d;
        valid_q      <= valid_d;
      end
    end

    assign pwm_out[g]   = out_q;
    assign pwm_busy[g]  = busy_q;
    assign pwm_valid[g] = valid_q;
  end

endmodule

// File: doc/pwm_multi_ch_gen.md
Name: pwm_multi_ch_gen

Overview:
- Parametrised multi-channel PWM generator that replaces the fixed free-running divider (hard-coded /25 toggle) and the per-instance pattern PWMs.
- Each channel has programmable period, duty, start phase, burst count, polarity and synchronous-start arming.
- Configured through a simple register-write port driven by the UART register mapper.
- Outputs feed the OBUF/ODDR/OBUFDS pin stages in the top level.

Parameters:
- NUM_CH, 4: number of independent PWM channels (1..16).
- CNT_WIDTH, 16: width of period/duty/phase counters and of cfg_wdata.
- BURST_WIDTH, 8: width of the burst-period counter (BURST=0 means infinite).

Ports:
- sys_clk  in  1  single system clock; all logic is on its rising edge.
- sys_rst  in  1  asynchronous reset, active-high.
- cfg_wr  in  1  single-cycle write strobe.
- cfg_ch  in  4  target channel; values >= NUM_CH are ignored.
- cfg_addr  in  3  register select: 0 CTRL, 1 PERIOD, 2 DUTY, 3 PHASE, 4 BURST; 5-7 are ignored.
- cfg_wdata  in  CNT_WIDTH  write data. CTRL uses bit0 en, bit1 pol, bit2 sync. BURST uses the low BURST_WIDTH bits.
- sync_start  in  1  global start pulse for armed channels.
- pwm_out  out  NUM_CH  registered PWM outputs.
- pwm_busy  out  NUM_CH  high while a channel is in RUN.
- pwm_valid  out  NUM_CH  one-cycle pulse when a burst completes.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - All registers clear to 0; every state goes to IDLE.
  - pwm_out = 0, pwm_busy = 0, pwm_valid = 0.
- Register staging:
  - PERIOD, DUTY, PHASE and BURST writes land in staging registers.
  - In IDLE or ARMED, active = staging.
  - In RUN, PERIOD and DUTY transfer to active only on the period-end cycle (cnt == PERIOD_act). No glitch or partial period is allowed.
  - PHASE and BURST take effect only at the next start.
- Per-channel state machine (IDLE / ARMED / RUN):
  - IDLE, CTRL write with en=1, sync=0: go to RUN; cnt = PHASE; burst_cnt = 0.
  - IDLE, CTRL write with en=1, sync=1: go to ARMED.
  - ARMED, sync_start=1: go to RUN. All armed channels start on the same edge with identical cnt initialisation.
  - ARMED or RUN, CTRL write with en=0: go to IDLE next edge. pwm_out goes to the idle level (pol); no pwm_valid pulse.
  - RUN, BURST != 0 and burst_cnt reaches BURST at period end: go to IDLE; pwm_valid = 1 for exactly one cycle; en self-clears.
- Counter:
  - Counts 0..PERIOD_act, so one period = PERIOD_act+1 clocks, then wraps to 0.
  - burst_cnt increments on each wrap, saturating at all-ones.
  - If PHASE > PERIOD at start, cnt loads 0.
- Output compare:
  - raw = (cnt < DUTY_act); pwm_out = raw XOR pol.
  - DUTY = 0 gives constant idle level.
  - DUTY > PERIOD gives constant active level.
  - PERIOD = 0 gives a one-clock period: output is constant; burst still counts one period per clock.
- Latency:
  - Write accepted at edge k: state = RUN after edge k+1.
  - pwm_out shows its first compare result after edge k+2 (one output register stage).
  - pwm_busy asserts together with that first compare output.
  - pwm_busy deasserts on the same edge that pwm_valid asserts.
- Simultaneous events:
  - CTRL en=0 on the period-end cycle of the last burst period: disable wins; no pwm_valid.
  - Staging write on a period-end cycle: the new value is used immediately.
  - sync_start with a CTRL write to the same channel: the CTRL write is evaluated first; sync_start only affects channels already in ARMED.
- Writes to CTRL while in RUN with en=1 update pol immediately; they do not restart the channel.

Test Plan:
- Default and reset check: PERIOD=9, DUTY=3, pol=0, en=1 on ch0. Expect repeating 3 high / 7 low, pwm_busy=1. Assert sys_rst mid-high: expect pwm_out=0 and busy=0 asynchronously.
- Burst: ch1 PERIOD=4, DUTY=2, BURST=3. Expect exactly 3 pulses of 2 clocks within 15 clocks. pwm_valid pulses once on the 15th clock; busy drops on the same edge.
- Sync start with phase:
  - ch0 PHASE=0, ch2 PHASE=5; both PERIOD=9, DUTY=5, sync=1.
  - Before sync_start, both stay ARMED with outputs low.
  - After sync_start, ch2 output is the inverse of ch0: ch0 high when ch2 low, 5-clock offset.
- Glitch-free update: running PERIOD=9, DUTY=3; write DUTY=7 at cnt=5. Current period keeps 3 high; the next period shows 7 high.
- Boundary:
  - DUTY=0 gives constant 0.
  - DUTY=12 with PERIOD=9 gives constant 1.
  - pol=1 inverts both cases.
  - PHASE=20 with PERIOD=9 starts at cnt=0.
  - cfg_ch=NUM_CH and cfg_addr=6 writes change nothing.
- Abort: en=0 during the last burst period, including exactly on the period-end cycle. Output returns to the idle level next edge; pwm_valid never asserts.
